// File: rtl/nor_read_seq.sv
// nor_read_seq: burst read sequencer issuing pipelined single-word wishbone reads
// and streaming the returned words through a small ready/valid FIFO.
module nor_read_seq #(
  parameter int MEMWBADDRBITS = 22,
  parameter int MEMWBDATABITS = 16,
  parameter int LENBITS       = 16,
  parameter int MAXOUT        = 2,
  parameter int FIFODEPTH     = 4
) (
  input  logic                     sys_clk_i,
  input  logic                     sys_rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [MEMWBADDRBITS-1:0] cmd_addr_i,
  input  logic [LENBITS-1:0]       cmd_len_i,
  input  logic                     abort_i,
  output logic [MEMWBADDRBITS-1:0] memwb_adr_o,
  output logic [MEMWBDATABITS-1:0] memwb_dat_o,
  output logic                     memwb_we_o,
  output logic                     memwb_stb_o,
  output logic                     memwb_cyc_o,
  input  logic                     memwb_ack_i,
  input  logic [MEMWBDATABITS-1:0] memwb_dat_i,
  input  logic                     memwb_stall_i,
  input  logic                     memwb_err_i,
  output logic                     out_valid_o,
  output logic [MEMWBDATABITS-1:0] out_data_o,
  output logic                     out_last_o,
  input  logic                     out_ready_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [1:0]               status_o
);
  localparam int OW = $clog2(MAXOUT + 1);
  localparam int CW = $clog2(FIFODEPTH + 1);
  localparam int PW = $clog2(FIFODEPTH);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_END} state_t;
  state_t state_q, state_d;
  logic cyc_q, cyc_d, abt_q, abt_d, err_q, err_d;
  logic [MEMWBADDRBITS-1:0] adr_q, adr_d;
  logic [LENBITS-1:0] rem_q, rem_d;
  logic [OW-1:0] out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wp_q, rp_q;
  logic [1:0] status_q, status_d;
  logic [MEMWBDATABITS-1:0] mem_q [FIFODEPTH];
  logic [FIFODEPTH-1:0] last_q;
  logic accept, stb, issue, ack_v, err_v, push, pop;
  assign accept = state_q == S_IDLE && cmd_valid_i;
  // reserving a FIFO slot per outstanding read means every ack can always be stored
  assign stb = state_q == S_RUN && rem_q != '0 && out_q < OW'(MAXOUT) &&
               int'(out_q) + int'(cnt_q) < FIFODEPTH && !abort_i;
  assign issue = stb && !memwb_stall_i;
  assign ack_v = memwb_ack_i && cyc_q;
  assign err_v = memwb_err_i && cyc_q;
  assign push = ack_v && !err_v && !abt_q && !err_q;
  assign pop = cnt_q != '0 && out_ready_i;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = accept ? (cmd_len_i != '0 ? S_RUN : S_DRAIN) : S_IDLE;
      S_RUN:   state_d = ((issue && rem_q == LENBITS'(1)) || abort_i || err_v) ? S_DRAIN : S_RUN;
      S_DRAIN: state_d = out_q == '0 ? S_END : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
    cyc_d = state_d == S_RUN || (state_d == S_DRAIN && cyc_q);
    abt_d = accept ? 1'b0 : abt_q || (abort_i && (state_q == S_RUN || state_q == S_DRAIN));
    err_d = accept ? 1'b0 : err_q || err_v;
    status_d = accept ? 2'b00 : state_d == S_END ? {err_d, abt_d} : status_q;
    adr_d = accept ? cmd_addr_i : adr_q + MEMWBADDRBITS'(issue);
    rem_d = accept ? cmd_len_i : rem_q - LENBITS'(issue);
    // a slave error terminates the cycle, so reads still in flight are written off
    out_d = err_v ? '0 : out_q + OW'(issue) - OW'(ack_v && out_q != '0);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q  <= S_IDLE;
      cyc_q    <= 1'b0;
      abt_q    <= 1'b0;
      err_q    <= 1'b0;
      status_q <= 2'b00;
      adr_q    <= '0;
      rem_q    <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      abt_q    <= abt_d;
      err_q    <= err_d;
      status_q <= status_d;
      adr_q    <= adr_d;
      rem_q    <= rem_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      wp_q     <= wp_q + PW'(push);
      rp_q     <= rp_q + PW'(pop);
    end
  end
  always_ff @(posedge sys_clk_i) begin
    if (push) begin
      mem_q[wp_q]  <= memwb_dat_i;
      last_q[wp_q] <= rem_q == '0 && out_q == OW'(1);
    end
  end
  assign cmd_ready_o = state_q == S_IDLE;
  assign busy_o      = state_q != S_IDLE;
  assign done_o      = state_q == S_END;
  assign status_o    = status_q;
  assign memwb_adr_o = adr_q;
  assign memwb_dat_o = '0;
  assign memwb_we_o  = 1'b0;
  assign memwb_stb_o = stb;
  assign memwb_cyc_o = cyc_q;
  assign out_valid_o = cnt_q != '0;
  assign out_data_o  = mem_q[rp_q];
  assign out_last_o  = cnt_q != '0 && last_q[rp_q];
endmodule

// File: tb/tb_nor_read_seq.sv
// tb_nor_read_seq: directed table plus randomized bursts against a queue-based
// wishbone slave and scoreboard for nor_read_seq.
module tb_nor_read_seq;
  localparam int AW = 22, DW = 16, LW = 16, MO = 2, FD = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, abort = 1'b0, stb, cyc, we;
  logic ack = 1'b0, stall = 1'b0, err = 1'b0, out_valid, out_last, out_ready = 1'b0, busy, done;
  logic [AW-1:0] cmd_addr = '0, adr;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] wdat, rdat = '0, out_data;
  logic [1:0] status;
  always #5 clk = ~clk;

  nor_read_seq #(.MEMWBADDRBITS(AW), .MEMWBDATABITS(DW), .LENBITS(LW), .MAXOUT(MO), .FIFODEPTH(FD)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .abort_i(abort), .memwb_adr_o(adr),
    .memwb_dat_o(wdat), .memwb_we_o(we), .memwb_stb_o(stb), .memwb_cyc_o(cyc),
    .memwb_ack_i(ack), .memwb_dat_i(rdat), .memwb_stall_i(stall), .memwb_err_i(err),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last), .out_ready_i(out_ready),
    .busy_o(busy), .done_o(done), .status_o(status));

  typedef struct { logic [AW-1:0] a; int due; } req_t;
  typedef struct {
    logic [AW-1:0] addr;
    int len, lat, stall_mode, ready_mode, abort_after, err_at;
    logic [1:0] status;
  } vec_t;

  int tests = 0, fails = 0, cyc_no = 0, acc = 0;
  req_t pend[$];
  logic [AW-1:0] issued[$];
  logic [DW-1:0] got[$];
  logic got_last[$];
  int lat, stall_mode, ready_mode, abort_after, err_at, stall_cnt, resp_idx;
  int clean_acks, issue_after_dirty, max_pend, done_cnt, cyc_in_done, hold_viol, done_cyc, got_at_done;
  bit dirty, abort_done, saw_done, cyc_seen, hold_valid, valid_at_done;
  logic [AW-1:0] hold_adr;
  vec_t tbl[7];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hC35A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // one clock of slave response, stimulus, observation; returns at posedge+1
  task automatic step();
    req_t r;
    ack = 1'b0; err = 1'b0; rdat = '0;
    if (pend.size() > 0 && pend[0].due <= cyc_no) begin
      r = pend.pop_front();
      resp_idx++;
      if (resp_idx == err_at) err = 1'b1;
      else begin ack = 1'b1; rdat = mem_word(r.a); end
    end
    abort = abort_after > 0 && !abort_done && issued.size() == abort_after && cyc;
    if (abort) abort_done = 1'b1;
    out_ready = ready_mode == 1 || (ready_mode == 0 && saw_done) || (ready_mode == 2 && $urandom_range(1, 0) == 1);
    stall = 1'b0;
    #1;
    if (stall_mode == 1) begin
      if (stb && issued.size() == 1 && stall_cnt < 3) begin stall = 1'b1; stall_cnt++; end
    end else if (stall_mode == 2) stall = stb && $urandom_range(2, 0) == 0;
    #1;
    if (hold_valid && stb && adr !== hold_adr) hold_viol++;
    hold_valid = stb && stall;
    hold_adr = adr;
    if (stb && !stall) begin
      issued.push_back(adr);
      r.a = adr; r.due = cyc_no + lat;
      pend.push_back(r);
      if (dirty) issue_after_dirty++;
    end
    if (pend.size() > max_pend) max_pend = pend.size();
    if (ack && cyc && !dirty) clean_acks++;
    if ((err && cyc) || abort) dirty = 1'b1;
    if (cyc) cyc_seen = 1'b1;
    if (done) begin
      done_cnt++; done_cyc = cyc_no; got_at_done = got.size(); valid_at_done = out_valid;
      if (cyc) cyc_in_done++;
      pend.delete();
      saw_done = 1'b1;
    end
    if (out_valid && out_ready) begin got.push_back(out_data); got_last.push_back(out_last); end
    @(posedge clk); #1;
    cyc_no++;
  endtask

  task automatic run_burst(input string nm, input vec_t v);
    int n, bad;
    bit clean;
    pend.delete(); issued.delete(); got.delete(); got_last.delete();
    lat = v.lat; stall_mode = v.stall_mode; ready_mode = v.ready_mode;
    abort_after = v.abort_after; err_at = v.err_at;
    stall_cnt = 0; resp_idx = 0; clean_acks = 0; issue_after_dirty = 0; max_pend = 0;
    done_cnt = 0; cyc_in_done = 0; hold_viol = 0; got_at_done = -1; done_cyc = -1;
    dirty = 0; abort_done = 0; saw_done = 0; cyc_seen = 0; hold_valid = 0; valid_at_done = 0;
    check({nm, " cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_len = LW'(v.len);
    acc = cyc_no;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!(saw_done && (ready_mode == 3 || !out_valid)) && n < 400) begin step(); n++; end
    check({nm, " timeout"}, n < 400, 1);
    clean = v.abort_after == 0 && v.err_at == 0;
    bad = 0;
    foreach (issued[i]) if (issued[i] !== v.addr + AW'(i)) bad++;
    check({nm, " addr_seq"}, bad, 0);
    if (v.err_at == 0) check({nm, " issue_count"}, issued.size(), clean ? v.len : v.abort_after);
    check({nm, " stb_after_stop"}, issue_after_dirty, 0);
    check({nm, " max_outstanding"}, max_pend <= MO, 1);
    check({nm, " stall_hold"}, hold_viol, 0);
    check({nm, " done_pulses"}, done_cnt, 1);
    check({nm, " cyc_in_end"}, cyc_in_done, 0);
    check({nm, " cyc_seen"}, cyc_seen, v.len != 0);
    check({nm, " status"}, status, v.status);
    if (v.len == 0) check({nm, " done_delay"}, done_cyc - acc, 2);
    if (v.ready_mode == 3) begin
      check({nm, " no_pop"}, got.size(), 0);
      check({nm, " fifo_held"}, out_valid, 1);
    end else begin
      check({nm, " word_count"}, got.size(), clean ? v.len : clean_acks);
      bad = 0;
      foreach (got[i])
        if (got[i] !== mem_word(v.addr + AW'(i)) || got_last[i] !== (clean && i == v.len - 1)) bad++;
      check({nm, " word_data"}, bad, 0);
    end
    if (v.ready_mode == 0) begin
      check({nm, " none_before_done"}, got_at_done, 0);
      check({nm, " full_at_done"}, valid_at_done, 1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    vec_t v;
    tbl[0] = '{22'h100,    4,  2, 0, 1, 0, 0, 2'b00};
    tbl[1] = '{22'h100,    4,  2, 0, 0, 0, 0, 2'b00};
    tbl[2] = '{22'h100,    4,  2, 1, 1, 0, 0, 2'b00};
    tbl[3] = '{22'h3FFFFF, 3,  2, 0, 1, 0, 0, 2'b00};
    tbl[4] = '{22'h040,    10, 2, 0, 1, 3, 0, 2'b01};
    tbl[5] = '{22'h300,    4,  2, 0, 1, 0, 2, 2'b10};
    tbl[6] = '{22'h3FFFFD, 6,  1, 2, 2, 0, 0, 2'b00};
    lat = 2; stall_mode = 0; ready_mode = 1; abort_after = 0; err_at = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst cmd_ready", cmd_ready, 1);
    check("rst busy", busy, 0);
    check("rst cyc", cyc, 0);
    check("rst stb", stb, 0);
    check("rst adr", adr, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_last", out_last, 0);
    check("rst done", done, 0);
    check("rst status", status, 0);
    foreach (tbl[i]) run_burst($sformatf("vec%0d", i), tbl[i]);
    run_burst("fill", '{22'h200, 4, 2, 0, 3, 0, 0, 2'b00});
    run_burst("len0", '{22'h000, 0, 2, 0, 3, 0, 0, 2'b00});
    check("len0 head_kept", out_data, mem_word(22'h200));
    ready_mode = 1; got.delete(); got_last.delete();
    repeat (4) step();
    check("drain count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      check($sformatf("drain word%0d", i), got[i], mem_word(22'h200 + AW'(i)));
      check($sformatf("drain last%0d", i), got_last[i], i == 3);
    end
    check("drain empty", out_valid, 0);
    for (int k = 0; k < 20; k++) begin
      v.addr = AW'($urandom);
      if (k % 4 == 0) v.addr = {AW{1'b1}} - AW'($urandom_range(4, 0));
      v.len = $urandom_range(9, 1);
      v.lat = $urandom_range(3, 1);
      v.stall_mode = 2 * $urandom_range(1, 0);
      v.ready_mode = $urandom_range(2, 1);
      v.abort_after = ($urandom_range(3, 0) == 0 && v.len > 1) ? $urandom_range(v.len - 1, 1) : 0;
      v.err_at = 0;
      v.status = v.abort_after != 0 ? 2'b01 : 2'b00;
      run_burst($sformatf("rnd%0d", k), v);
    end
    pend.delete(); issued.delete(); lat = 2; stall_mode = 0; ready_mode = 0;
    abort_after = 0; err_at = 0; saw_done = 0;
    cmd_valid = 1'b1; cmd_addr = 22'h500; cmd_len = 16'd8;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    check("midrst cyc_before", cyc, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    pend.delete();
    check("midrst cyc", cyc, 0);
    check("midrst stb", stb, 0);
    check("midrst busy", busy, 0);
    check("midrst cmd_ready", cmd_ready, 1);
    check("midrst out_valid", out_valid, 0);
    check("midrst adr", adr, 0);
    check("midrst status", status, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
